costas_loop_filter: RTL and testbench

- Upstream neighbour of the NCO phase stage: converts the Costas-loop baseband I/Q arm outputs into the signed feedback word the NCO phase stage adds to its free-running frequency.
- Contains a selectable phase detector, a proportional-integral loop filter with a saturating integrator, and a hysteretic lock detector.
- Streaming: valid-only, no backpressure, one sample per clock maximum.

---
 rtl/costas_loop_filter_pkg.sv | 29 ++
 rtl/costas_lock_detector.sv | 74 +++++++
 rtl/costas_loop_filter.sv | 113 +++++++++++
 tb/tb_costas_loop_filter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/costas_loop_filter_pkg.sv
// Shared types and helpers for the Costas loop filter: detector modes, lock FSM
// states and a generic signed saturation function.
package costas_loop_filter_pkg;

  typedef enum logic {
    PdProduct = 1'b0,
    PdSign    = 1'b1
  } pd_mode_e;

  typedef enum logic {
    StUnlocked = 1'b0,
    StLocked   = 1'b1
  } lock_state_e;

  // Working width for intermediate arithmetic; callers truncate the result.
  localparam int unsigned SatW = 64;

  function automatic logic signed [SatW-1:0] sat_s(input logic signed [SatW-1:0] v,
                                                   input int unsigned             w);
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/costas_lock_detector.sv
// Hysteretic lock detector: counts consecutive in-lock / out-of-lock phase
// error samples and toggles the registered lock flag.
module costas_lock_detector
  import costas_loop_filter_pkg::*;
#(
  parameter int unsigned       WIDTH        = 16,
  parameter logic [WIDTH-1:0]  LOCK_THRESH  = 16'd1024,
  parameter int unsigned       LOCK_COUNT   = 256,
  parameter int unsigned       UNLOCK_COUNT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] err_i,
  input  logic                    err_valid_i,
  output logic                    locked_o
);

  localparam int unsigned InW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned OutW = $clog2(UNLOCK_COUNT + 1);

  lock_state_e      state_q;
  logic [InW-1:0]   cnt_in_q;
  logic [OutW-1:0]  cnt_out_q;
  logic [WIDTH-1:0] mag;
  logic             in_lock;

  // |err| with the most negative code pinned to the most positive one.
  always_comb begin
    if (!err_i[WIDTH-1]) begin
      mag = err_i;
    end else if (err_i == {1'b1, {(WIDTH-1){1'b0}}}) begin
      mag = {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      mag = WIDTH'(-err_i);
    end
    in_lock = (mag < LOCK_THRESH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StUnlocked;
      cnt_in_q  <= '0;
      cnt_out_q <= '0;
      locked_o  <= 1'b0;
    end else if (err_valid_i) begin
      unique case (state_q)
        StUnlocked: begin
          if (!in_lock) begin
            cnt_in_q <= '0;
          end else if (cnt_in_q == InW'(LOCK_COUNT - 1)) begin
            state_q  <= StLocked;
            locked_o <= 1'b1;
            cnt_in_q <= '0;
          end else if (cnt_in_q != '1) begin
            cnt_in_q <= cnt_in_q + 1'b1;
          end
        end
        StLocked: begin
          if (in_lock) begin
            cnt_out_q <= '0;
          end else if (cnt_out_q == OutW'(UNLOCK_COUNT - 1)) begin
            state_q   <= StUnlocked;
            locked_o  <= 1'b0;
            cnt_out_q <= '0;
          end else if (cnt_out_q != '1) begin
            cnt_out_q <= cnt_out_q + 1'b1;
          end
        end
        default: state_q <= StUnlocked;
      endcase
    end
  end

endmodule

// File: rtl/costas_loop_filter.sv
// Costas loop filter: phase detector, PI filter with saturating integrator and
// lock detector; three-stage valid-only pipeline feeding the NCO phase stage.
module costas_loop_filter
  import costas_loop_filter_pkg::*;
#(
  parameter int unsigned      WIDTH        = 16,
  parameter int unsigned      ACC_WIDTH    = 24,
  parameter logic [WIDTH-1:0] LOCK_THRESH  = 16'd1024,
  parameter int unsigned      LOCK_COUNT   = 256,
  parameter int unsigned      UNLOCK_COUNT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    PD_MODE,
  input  logic [3:0]              KP_SHIFT,
  input  logic [3:0]              KI_SHIFT,
  input  logic                    integ_clear,
  input  logic signed [WIDTH-1:0] iq_tdata_i,
  input  logic signed [WIDTH-1:0] iq_tdata_q,
  input  logic                    iq_tvalid,
  output logic signed [WIDTH-1:0] feedback_tdata,
  output logic                    feedback_tvalid,
  output logic                    locked
);

  logic signed [2*WIDTH-1:0]   prod;
  logic signed [SatW-1:0]      pd_raw;
  logic signed [WIDTH-1:0]     err_d, err_q;
  logic                        s1_vld_q;

  logic signed [ACC_WIDTH-1:0] prop_d, prop_q;
  logic signed [ACC_WIDTH-1:0] integ_d, integ_q;
  logic                        s2_vld_q;

  logic signed [WIDTH-1:0]     fb_d;

  // S1: phase detector
  always_comb begin
    prod = iq_tdata_i * iq_tdata_q;
    if (pd_mode_e'(PD_MODE) == PdSign) begin
      if (iq_tdata_i[WIDTH-1]) begin
        pd_raw = -SatW'(iq_tdata_q);
      end else begin
        pd_raw = SatW'(iq_tdata_q);
      end
    end else begin
      pd_raw = SatW'(prod >>> (WIDTH - 1));
    end
    err_d = WIDTH'(sat_s(pd_raw, WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q    <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= iq_tvalid;
      if (iq_tvalid) err_q <= err_d;
    end
  end

  // S2: proportional term and integrator; a clear wins over an update.
  always_comb begin
    prop_d  = ACC_WIDTH'(err_q >>> KP_SHIFT);
    integ_d = integ_q;
    if (integ_clear) begin
      integ_d = '0;
    end else if (s1_vld_q) begin
      integ_d = ACC_WIDTH'(sat_s(SatW'(integ_q) + SatW'(err_q >>> KI_SHIFT), ACC_WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prop_q   <= '0;
      integ_q  <= '0;
      s2_vld_q <= 1'b0;
    end else begin
      s2_vld_q <= s1_vld_q;
      integ_q  <= integ_d;
      if (s1_vld_q) prop_q <= prop_d;
    end
  end

  // S3: output uses the integrator value already updated by this sample.
  always_comb begin
    fb_d = WIDTH'(sat_s(sat_s(SatW'(prop_q) + SatW'(integ_q), ACC_WIDTH), WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      feedback_tdata  <= '0;
      feedback_tvalid <= 1'b0;
    end else begin
      feedback_tvalid <= s2_vld_q;
      if (s2_vld_q) feedback_tdata <= fb_d;
    end
  end

  costas_lock_detector #(
    .WIDTH        (WIDTH),
    .LOCK_THRESH  (LOCK_THRESH),
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_COUNT (UNLOCK_COUNT)
  ) u_lock (
    .clk         (clk),
    .rst         (rst),
    .err_i       (err_q),
    .err_valid_i (s1_vld_q),
    .locked_o    (locked)
  );

endmodule

// File: tb/tb_costas_loop_filter.sv
// Directed self-checking bench for costas_loop_filter.
module tb_costas_loop_filter;

  localparam int unsigned W = 16;

  typedef struct {
    logic pd;
    int   i;
    int   q;
    int   e;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                pd_mode;
  logic [3:0]          kp, ki;
  logic                integ_clear;
  logic signed [W-1:0] di, dq;
  logic                dv;
  logic signed [W-1:0] fb;
  logic                fbv;
  logic                locked;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[5];

  always #5 clk = ~clk;

  costas_loop_filter dut (
    .clk             (clk),
    .rst             (rst),
    .PD_MODE         (pd_mode),
    .KP_SHIFT        (kp),
    .KI_SHIFT        (ki),
    .integ_clear     (integ_clear),
    .iq_tdata_i      (di),
    .iq_tdata_q      (dq),
    .iq_tvalid       (dv),
    .feedback_tdata  (fb),
    .feedback_tvalid (fbv),
    .locked          (locked)
  );

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one input beat, then sample just after the clock edge.
  task automatic drive(input logic v, input logic signed [W-1:0] i,
                       input logic signed [W-1:0] q);
    dv = v;
    di = i;
    dq = q;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0);
  endtask

  task automatic clear_integ();
    integ_clear = 1'b1;
    idle(1);
    integ_clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pd_mode = 1'b0; kp = '0; ki = '0; integ_clear = 1'b0;
    dv = 1'b0; di = '0; dq = '0;
    vecs[0] = '{1'b0, -16384,   8192,  -4097};
    vecs[1] = '{1'b1,     -5,   1000,  -1002};
    vecs[2] = '{1'b1,      0, -32768, -32768};
    vecs[3] = '{1'b1,     -1, -32768,  32764};
    vecs[4] = '{1'b0, -32768, -32768,  32764};

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_fb", fb, 0);
    check_eq("rst_fbv", fbv, 0);
    check_eq("rst_locked", locked, 0);
    rst = 1'b0;

    // Product detector, err = 4096: prop 1024, integrator +64 per sample.
    kp = 4'd2; ki = 4'd6;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 16'sd16384, 16'sd8192);
      if (c < 2) begin
        check_eq("prod_latency", fbv, 0);
      end else begin
        check_eq("prod_vld", fbv, 1);
        check_eq("prod_data", fb, 1024 + 64 * (c - 1));
      end
    end
    idle(3);
    check_eq("prod_drain", fbv, 0);
    clear_integ();

    // Bubbles: valid on even beats only, output mirrors the pattern 3 cycles later.
    for (int c = 0; c < 10; c++) begin
      drive((c < 8) && (c % 2 == 0), 16'sd16384, 16'sd8192);
      if (c >= 2) begin
        check_eq("bub_vld", fbv, ((c - 2) % 2 == 0));
        if ((c - 2) % 2 == 0) check_eq("bub_data", fb, 1024 + 64 * ((c - 2) / 2 + 1));
      end
    end
    check_eq("bub_integ", dut.integ_q, 256);

    // Clear coinciding with a valid sample in the filter stage.
    drive(1'b1, 16'sd16384, 16'sd8192);
    integ_clear = 1'b1;
    idle(1);
    integ_clear = 1'b0;
    idle(1);
    check_eq("clr_data", fb, 1024);
    check_eq("clr_vld", fbv, 1);
    drive(1'b1, 16'sd16384, 16'sd8192);
    idle(2);
    check_eq("clr_next", fb, 1088);
    idle(3);
    clear_integ();

    // Mixed detector vectors incl. saturated negation and output saturation.
    kp = 4'd0; ki = 4'd15;
    for (int k = 0; k < 7; k++) begin
      if (k < 5) begin
        pd_mode = vecs[k].pd;
        drive(1'b1, 16'(vecs[k].i), 16'(vecs[k].q));
      end else begin
        idle(1);
      end
      if (k >= 2) check_eq("pd_vec", fb, vecs[k-2].e);
    end
    idle(3);
    clear_integ();

    // Integrator saturation: err = 32767, no proportional contribution.
    pd_mode = 1'b1; kp = 4'd15; ki = 4'd0;
    repeat (300) drive(1'b1, 16'sd0, 16'sd32767);
    check_eq("sat_fbv", fbv, 1);
    check_eq("sat_fb", fb, 32767);
    idle(3);
    check_eq("sat_integ", dut.integ_q, 8388607);

    rst = 1'b1;
    idle(1);
    rst = 1'b0;

    // Lock hysteresis, threshold boundary at |err| = 1024.
    repeat (255) drive(1'b1, 16'sd0, 16'sd1023);
    idle(2);
    check_eq("lock_255", locked, 0);
    drive(1'b1, 16'sd0, -16'sd1023);
    idle(2);
    check_eq("lock_256", locked, 1);
    for (int k = 0; k < 63; k++) begin
      drive(1'b1, 16'sd0, (k % 3 == 0) ? -16'sd32768 : ((k % 3 == 1) ? 16'sd1024 : -16'sd1024));
    end
    drive(1'b1, 16'sd0, 16'sd5);
    idle(2);
    check_eq("hold_after_63", locked, 1);
    repeat (63) drive(1'b1, 16'sd0, 16'sd1024);
    idle(2);
    check_eq("unlock_63", locked, 1);
    drive(1'b1, -16'sd1, -16'sd32768);
    idle(2);
    check_eq("unlock_64", locked, 0);

    // Reset with a full pipeline and lock asserted.
    kp = 4'd0; ki = 4'd15;
    repeat (256) drive(1'b1, 16'sd0, 16'sd100);
    idle(2);
    check_eq("relock", locked, 1);
    repeat (3) drive(1'b1, 16'sd0, 16'sd100);
    rst = 1'b1;
    drive(1'b1, 16'sd0, 16'sd100);
    check_eq("mid_rst_fb", fb, 0);
    check_eq("mid_rst_fbv", fbv, 0);
    check_eq("mid_rst_locked", locked, 0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 16'sd0, 16'sd100);
      check_eq("post_rst_vld", fbv, (c == 2));
    end
    check_eq("post_rst_data", fb, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
